// File: rtl/vga_timing_pkg.sv
// Shared mode tables and sizing helper for the VGA timing generator family.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel rate
    localparam int VGA640_H_PIXELS      = 640;
    localparam int VGA640_H_FRONT_PORCH = 16;
    localparam int VGA640_H_SYNC_PULSE  = 96;
    localparam int VGA640_H_BACK_PORCH  = 48;
    localparam int VGA640_V_LINES       = 480;
    localparam int VGA640_V_FRONT_PORCH = 10;
    localparam int VGA640_V_SYNC_PULSE  = 2;
    localparam int VGA640_V_BACK_PORCH  = 33;
    localparam bit VGA640_H_POL         = 1'b0;
    localparam bit VGA640_V_POL         = 1'b0;

    // 800x600 @ 60 Hz, 40 MHz pixel rate
    localparam int VGA800_H_PIXELS      = 800;
    localparam int VGA800_H_FRONT_PORCH = 40;
    localparam int VGA800_H_SYNC_PULSE  = 128;
    localparam int VGA800_H_BACK_PORCH  = 88;
    localparam int VGA800_V_LINES       = 600;
    localparam int VGA800_V_FRONT_PORCH = 1;
    localparam int VGA800_V_SYNC_PULSE  = 4;
    localparam int VGA800_V_BACK_PORCH  = 23;
    localparam bit VGA800_H_POL         = 1'b1;
    localparam bit VGA800_V_POL         = 1'b1;

    // Bits needed to hold values 0..value-1; use clog2(TOTAL) when sizing CW.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-qualified shift register used to align timing outputs with pixel-fetch latency.
module vga_delay_line
    import vga_timing_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused;
            assign unused = &{1'b0, clk, reset, en};
            assign dout   = din;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] sr;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else if (en) begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA scan generator: sync, display enable, coordinates and strobes,
// advanced by a pixel-clock enable and delayable to match downstream latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_PIXELS      = VGA640_H_PIXELS,
    parameter int H_FRONT_PORCH = VGA640_H_FRONT_PORCH,
    parameter int H_SYNC_PULSE  = VGA640_H_SYNC_PULSE,
    parameter int H_BACK_PORCH  = VGA640_H_BACK_PORCH,
    parameter bit H_POL         = VGA640_H_POL,
    parameter int V_LINES       = VGA640_V_LINES,
    parameter int V_FRONT_PORCH = VGA640_V_FRONT_PORCH,
    parameter int V_SYNC_PULSE  = VGA640_V_SYNC_PULSE,
    parameter int V_BACK_PORCH  = VGA640_V_BACK_PORCH,
    parameter bit V_POL         = VGA640_V_POL,
    parameter int PIPE_DELAY    = 0,
    parameter int CW            = 12,
    parameter int FC_W          = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pix_en,
    output logic            h_sync,
    output logic            v_sync,
    output logic            display_enable,
    output logic [CW-1:0]   column,
    output logic [CW-1:0]   row,
    output logic            line_start,
    output logic            frame_start,
    output logic            v_blank,
    output logic [FC_W-1:0] frame_count
);

    localparam int H_TOTAL  = H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL  = V_LINES + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HS_START = H_PIXELS + H_FRONT_PORCH;
    localparam int HS_STOP  = HS_START + H_SYNC_PULSE;
    localparam int VS_START = V_LINES + V_FRONT_PORCH;
    localparam int VS_STOP  = VS_START + V_SYNC_PULSE;
    localparam int BW       = 2 * CW + 6;

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_last, v_last;

    assign h_last = (h_cnt == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt == CW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_count <= '0;
        end else if (pix_en) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
            if (h_last && v_last) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    // Syncs are carried active-high internally so a cleared pipeline means "inactive".
    logic de_c, hs_c, vs_c, ls_c, fs_c, vb_c;

    always_comb begin
        de_c = (h_cnt < CW'(H_PIXELS)) && (v_cnt < CW'(V_LINES));
        hs_c = (h_cnt >= CW'(HS_START)) && (h_cnt < CW'(HS_STOP));
        vs_c = (v_cnt >= CW'(VS_START)) && (v_cnt < CW'(VS_STOP));
        ls_c = (h_cnt == '0);
        fs_c = (h_cnt == '0) && (v_cnt == '0);
        vb_c = (v_cnt >= CW'(V_LINES));
    end

    logic [BW-1:0] s0, sq;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0 <= '0;
        end else if (pix_en) begin
            s0 <= {de_c, hs_c, vs_c, ls_c, fs_c, vb_c,
                   de_c ? h_cnt : '0, de_c ? v_cnt : '0};
        end
    end

    vga_delay_line #(
        .WIDTH (BW),
        .DEPTH (PIPE_DELAY)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .din   (s0),
        .dout  (sq)
    );

    // Strobes are qualified by "a tick just happened" so held stages don't repeat them.
    logic fresh;

    always_ff @(posedge clk) begin
        if (reset) begin
            fresh <= 1'b0;
        end else begin
            fresh <= pix_en;
        end
    end

    logic          de_q, hs_q, vs_q, ls_q, fs_q, vb_q;
    logic [CW-1:0] col_q, row_q;

    assign {de_q, hs_q, vs_q, ls_q, fs_q, vb_q, col_q, row_q} = sq;

    assign h_sync         = hs_q ? H_POL : ~H_POL;
    assign v_sync         = vs_q ? V_POL : ~V_POL;
    assign display_enable = de_q;
    assign column         = col_q;
    assign row            = row_q;
    assign line_start     = ls_q & fresh;
    assign frame_start    = fs_q & fresh;
    assign v_blank        = vb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised pix_en stimulus on three generator configurations, checked each cycle
// against an arithmetic scan model plus literal per-frame pins.
module tb_vga_timing_gen;

    typedef struct packed {
        int hp, hf, hs, hb, vl, vf, vs, vb, hpol, vpol, pd, fcw;
    } mode_t;

    typedef struct {
        logic [31:0] hs, vs, de, ls, fs, vb, col, row, fc;
    } obs_t;

    localparam mode_t MA = '{hp:8, hf:2, hs:3, hb:1, vl:4, vf:1, vs:2, vb:1,
                             hpol:0, vpol:0, pd:0, fcw:8};
    localparam mode_t MB = '{hp:8, hf:2, hs:3, hb:1, vl:4, vf:1, vs:2, vb:1,
                             hpol:1, vpol:1, pd:3, fcw:8};
    localparam mode_t MC = '{hp:20, hf:4, hs:6, hb:2, vl:10, vf:2, vs:2, vb:3,
                             hpol:1, vpol:0, pd:2, fcw:2};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic        a_hs, a_vs, a_de, a_ls, a_fs, a_vb;
    logic [11:0] a_col, a_row;
    logic [7:0]  a_fc;
    logic        b_hs, b_vs, b_de, b_ls, b_fs, b_vb;
    logic [11:0] b_col, b_row;
    logic [7:0]  b_fc;
    logic        c_hs, c_vs, c_de, c_ls, c_fs, c_vb;
    logic [11:0] c_col, c_row;
    logic [1:0]  c_fc;

    vga_timing_gen #(
        .H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(1), .H_POL(1'b0),
        .V_LINES(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1), .V_POL(1'b0),
        .PIPE_DELAY(0), .CW(12), .FC_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(a_hs), .v_sync(a_vs),
        .display_enable(a_de), .column(a_col), .row(a_row), .line_start(a_ls),
        .frame_start(a_fs), .v_blank(a_vb), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(1), .H_POL(1'b1),
        .V_LINES(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1), .V_POL(1'b1),
        .PIPE_DELAY(3), .CW(12), .FC_W(8)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(b_hs), .v_sync(b_vs),
        .display_enable(b_de), .column(b_col), .row(b_row), .line_start(b_ls),
        .frame_start(b_fs), .v_blank(b_vb), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_PIXELS(20), .H_FRONT_PORCH(4), .H_SYNC_PULSE(6), .H_BACK_PORCH(2), .H_POL(1'b1),
        .V_LINES(10), .V_FRONT_PORCH(2), .V_SYNC_PULSE(2), .V_BACK_PORCH(3), .V_POL(1'b0),
        .PIPE_DELAY(2), .CW(12), .FC_W(2)
    ) dut_c (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(c_hs), .v_sync(c_vs),
        .display_enable(c_de), .column(c_col), .row(c_row), .line_start(c_ls),
        .frame_start(c_fs), .v_blank(c_vb), .frame_count(c_fc)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs follow the counter index (ticks since reset - 1 - delay) by plain arithmetic.
    function automatic obs_t model(input mode_t m, input int nt, input bit f);
        obs_t e;
        int ht, vt, idx, h, v;
        bit de;
        ht = m.hp + m.hf + m.hs + m.hb;
        vt = m.vl + m.vf + m.vs + m.vb;
        idx = nt - 1 - m.pd;
        e.fc = (nt / (ht * vt)) % (1 << m.fcw);
        e.hs = (m.hpol == 0) ? 1 : 0;
        e.vs = (m.vpol == 0) ? 1 : 0;
        e.de = 0; e.ls = 0; e.fs = 0; e.vb = 0; e.col = 0; e.row = 0;
        if (idx >= 0) begin
            h = idx % ht;
            v = (idx / ht) % vt;
            de = (h < m.hp) && (v < m.vl);
            e.de  = de ? 1 : 0;
            e.hs  = (h >= m.hp + m.hf && h < m.hp + m.hf + m.hs) ? m.hpol : 1 - m.hpol;
            e.vs  = (v >= m.vl + m.vf && v < m.vl + m.vf + m.vs) ? m.vpol : 1 - m.vpol;
            e.col = de ? h : 0;
            e.row = de ? v : 0;
            e.ls  = (f && h == 0) ? 1 : 0;
            e.fs  = (f && h == 0 && v == 0) ? 1 : 0;
            e.vb  = (v >= m.vl) ? 1 : 0;
        end
        return e;
    endfunction

    function automatic obs_t mk(input logic hs, vs, de, ls, fs, vb,
                                input logic [31:0] col, row, fc);
        obs_t o;
        o.hs = {31'b0, hs}; o.vs = {31'b0, vs}; o.de = {31'b0, de};
        o.ls = {31'b0, ls}; o.fs = {31'b0, fs}; o.vb = {31'b0, vb};
        o.col = col; o.row = row; o.fc = fc;
        return o;
    endfunction

    task automatic chk_obs(input string who, input obs_t a, input obs_t e);
        chk({who, "_h_sync"}, a.hs, e.hs);
        chk({who, "_v_sync"}, a.vs, e.vs);
        chk({who, "_display_enable"}, a.de, e.de);
        chk({who, "_line_start"}, a.ls, e.ls);
        chk({who, "_frame_start"}, a.fs, e.fs);
        chk({who, "_v_blank"}, a.vb, e.vb);
        chk({who, "_column"}, a.col, e.col);
        chk({who, "_row"}, a.row, e.row);
        chk({who, "_frame_count"}, a.fc, e.fc);
    endtask

    // Reference state: pix_en ticks since reset, and whether the last edge was a tick.
    int n = 0;
    bit fr = 1'b0;
    bit rst_d = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            n = 0;
            fr = 1'b0;
        end else if (pix_en) begin
            n = n + 1;
            fr = 1'b1;
        end else begin
            fr = 1'b0;
        end
        rst_d = reset;
    end

    bit run = 1'b0;
    int a_tk = 0, a_de_n = 0, a_hs_n = 0, a_vs_n = 0;
    bit a_seen = 1'b0;
    int b_tk = 0, b_hs_n = 0;
    bit b_seen = 1'b0;
    int c_de_n = 0, c_max_col = 0, c_max_row = 0;
    bit c_seen = 1'b0, c_wrap = 1'b0;
    int c_prev_fc = 0;
    int rel = 0;
    bit pend_a = 1'b0, pend_b = 1'b0, pend_c = 1'b0;
    int fs_act_a = 0, fs_exp_a = 0, fs_act_c = 0, fs_exp_c = 0;

    always @(negedge clk) begin
        obs_t oa, ob, oc;
        if (run) begin
            oa = mk(a_hs, a_vs, a_de, a_ls, a_fs, a_vb, 32'(a_col), 32'(a_row), 32'(a_fc));
            ob = mk(b_hs, b_vs, b_de, b_ls, b_fs, b_vb, 32'(b_col), 32'(b_row), 32'(b_fc));
            oc = mk(c_hs, c_vs, c_de, c_ls, c_fs, c_vb, 32'(c_col), 32'(c_row), 32'(c_fc));
            chk_obs("A", oa, model(MA, n, fr));
            chk_obs("B", ob, model(MB, n, fr));
            chk_obs("C", oc, model(MC, n, fr));
            fs_act_a += oa.fs; fs_exp_a += model(MA, n, fr).fs;
            fs_act_c += oc.fs; fs_exp_c += model(MC, n, fr).fs;

            if (rst_d) begin
                chk("A_rst_h_sync", oa.hs, 1);
                chk("A_rst_v_sync", oa.vs, 1);
                chk("B_rst_h_sync", ob.hs, 0);
                chk("B_rst_v_sync", ob.vs, 0);
                chk("A_rst_de", oa.de, 0);
                chk("B_rst_column", ob.col, 0);
                chk("C_rst_frame_count", oc.fc, 0);
                a_seen = 0; b_seen = 0; c_seen = 0;
                pend_a = 1; pend_b = 1; pend_c = 1;
                rel = 0;
            end else begin
                if (c_prev_fc == 3 && oc.fc == 0) c_wrap = 1;
            end
            c_prev_fc = oc.fc;
            if (oc.de == 1) begin
                if (oc.col > c_max_col) c_max_col = oc.col;
                if (oc.row > c_max_row) c_max_row = oc.row;
            end

            if (fr) begin
                rel++;
                if (oa.fs == 1 && pend_a) begin chk("A_fs_latency", rel, 1); pend_a = 0; end
                if (ob.fs == 1 && pend_b) begin chk("B_fs_latency", rel, 4); pend_b = 0; end
                if (oc.fs == 1 && pend_c) begin chk("C_fs_latency", rel, 3); pend_c = 0; end

                if (oa.fs == 1) begin
                    if (a_seen) begin
                        chk("A_ticks_per_frame", a_tk, 112);
                        chk("A_de_per_frame", a_de_n, 32);
                        chk("A_hsync_ticks_per_frame", a_hs_n, 24);
                        chk("A_vsync_ticks_per_frame", a_vs_n, 28);
                    end
                    a_seen = 1; a_tk = 0; a_de_n = 0; a_hs_n = 0; a_vs_n = 0;
                end
                a_tk++;
                if (oa.de == 1) a_de_n++;
                if (oa.hs == 0) a_hs_n++;
                if (oa.vs == 0) a_vs_n++;

                if (ob.fs == 1) begin
                    if (b_seen) begin
                        chk("B_ticks_per_frame", b_tk, 112);
                        chk("B_hsync_ticks_per_frame", b_hs_n, 24);
                    end
                    b_seen = 1; b_tk = 0; b_hs_n = 0;
                end
                b_tk++;
                if (ob.hs == 1) b_hs_n++;

                if (oc.fs == 1) begin
                    if (c_seen) chk("C_de_per_frame", c_de_n, 200);
                    c_seen = 1; c_de_n = 0;
                end
                if (oc.de == 1) c_de_n++;
            end
        end
    end

    task automatic drive(input bit r, input bit e);
        @(negedge clk);
        #1;
        reset = r;
        pix_en = e;
    endtask

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        run = 1'b1;
        // free-running pixel ticks: frames 0, 1, 2
        for (int i = 0; i < 3 * 112 + 5; i++) drive(1'b0, 1'b1);
        // pix_en toggling 1-0
        for (int i = 0; i < 2 * 2 * 112 + 4; i++) drive(1'b0, (i % 2) == 0);
        // random pix_en
        for (int i = 0; i < 600; i++) drive(1'b0, $urandom_range(0, 3) != 0);
        // reset while config A counter holds h=5, v=2
        guard = 0;
        while (!((n % 14) == 5 && ((n / 14) % 8) == 2) && guard < 500) begin
            drive(1'b0, 1'b1);
            guard++;
        end
        chk("reset_point_reached", (guard < 500) ? 1 : 0, 1);
        drive(1'b1, 1'b1);
        drive(1'b1, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 300; i++) drive(1'b0, $urandom_range(0, 2) != 0);
        // long run so config C (FC_W=2) completes 5 frames and wraps
        drive(1'b1, 1'b0);
        for (int i = 0; i < 5 * 544 + 100; i++) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("C_max_column", c_max_col, 19);
        chk("C_max_row", c_max_row, 9);
        chk("C_frame_count_wrap_3_to_0", {31'b0, c_wrap}, 1);
        chk("A_frame_start_total", fs_act_a, fs_exp_a);
        chk("C_frame_start_total", fs_act_c, fs_exp_c);
        chk("B_fs_after_reset_pending", {31'b0, pend_b}, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
